// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a uart transmitter through its tx_data/tx_strobe/tx_busy handshake.
// Bursty writes are buffered and drained one byte per uart frame.
module uart_tx_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned BUSY_WAIT  = 3
) (
    input  logic                  raw_clk,
    input  logic                  reset,
    input  logic [7:0]            wr_data,
    input  logic                  wr_strobe,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    input  logic                  overflow_clear,
    output logic [7:0]            tx_data,
    output logic                  tx_strobe,
    input  logic                  tx_busy
);

    localparam int unsigned Depth = 1 << DEPTH_LOG2;
    localparam int unsigned WaitW = (BUSY_WAIT > 1) ? $clog2(BUSY_WAIT) : 1;
    localparam logic [WaitW-1:0]      WaitLast = WaitW'(BUSY_WAIT - 1);
    localparam logic [DEPTH_LOG2:0]   CountFull = (DEPTH_LOG2 + 1)'(Depth);
    localparam logic [DEPTH_LOG2:0]   CountOne = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PtrOne = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {
        StIdle,
        StStrobe,
        StWaitBusy,
        StWaitDone
    } state_e;

    state_e                state_q, state_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  tx_strobe_q, tx_strobe_d;
    logic [WaitW-1:0]      wait_cnt_q, wait_cnt_d;
    logic [7:0]            mem_q [Depth];

    logic pop;
    logic wr_accept;

    assign full      = (count_q == CountFull);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign tx_data   = tx_data_q;
    assign tx_strobe = tx_strobe_q;

    always_comb begin
        state_d     = state_q;
        tx_data_d   = tx_data_q;
        tx_strobe_d = tx_strobe_q;
        wait_cnt_d  = wait_cnt_q;
        pop         = 1'b0;

        unique case (state_q)
            StIdle: begin
                // empty reflects the count register, so a byte written this cycle waits one cycle
                if (!empty && !tx_busy) begin
                    pop         = 1'b1;
                    tx_data_d   = mem_q[rd_ptr_q];
                    tx_strobe_d = 1'b1;
                    state_d     = StStrobe;
                end
            end
            StStrobe: begin
                tx_strobe_d = 1'b0;
                wait_cnt_d  = '0;
                state_d     = StWaitBusy;
            end
            StWaitBusy: begin
                if (tx_busy) begin
                    state_d = StWaitDone;
                end else if (wait_cnt_q == WaitLast) begin
                    // uart never acknowledged; the byte is treated as lost
                    state_d = StIdle;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            StWaitDone: begin
                if (!tx_busy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_accept  = wr_strobe && (!full || pop);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end

        if (wr_accept && !pop) begin
            count_d = count_q + CountOne;
        end else if (!wr_accept && pop) begin
            count_d = count_q - CountOne;
        end

        // set beats clear when both happen together
        if (overflow_clear) begin
            overflow_d = 1'b0;
        end
        if (wr_strobe && !wr_accept) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge raw_clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            tx_strobe_q <= 1'b0;
            wait_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            tx_data_q   <= tx_data_d;
            tx_strobe_q <= tx_strobe_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    // Storage is not reset; contents are meaningless until written.
    always_ff @(posedge raw_clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule
